sel_arbiter4: RTL and testbench

- Round-robin arbiter that produces the 4-bit one-hot select consumed by the datapath's one-hot 4:1 muxes. It is the producer side of that select interface.
- Four requesters each present a WIDTH-bit word. The arbiter picks one fairly, registers its word, and holds a one-hot Sel plus valid data until the downstream consumer accepts.
- It then returns a one-cycle Ack to the winning requester.
- Sits between the multi-cycle write-back sources and the register-file write port.

---
 rtl/sel_arbiter4_pkg.sv | 30 +++
 rtl/sel_arbiter4_if.sv | 44 ++++
 rtl/sel_arbiter4_chk.sv | 41 ++++
 rtl/sel_arbiter4_rr_pick4.sv | 40 ++++
 rtl/sel_arbiter4.sv | 128 ++++++++++++
 tb/tb_sel_arbiter4.sv | 244 ++++++++++++++++++++++++
 6 files changed

// File: rtl/sel_arbiter4_pkg.sv
// Shared encodings for the round-robin select arbiter: FSM states and the
// one-hot select codes decoded by the datapath 4:1 muxes.
package sel_arbiter4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_0    = 4'b0001;
    localparam logic [3:0] SEL_1    = 4'b0010;
    localparam logic [3:0] SEL_2    = 4'b0100;
    localparam logic [3:0] SEL_3    = 4'b1000;

    // Index to the one-hot select code the muxes expect.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] code;
        case (idx)
            2'd0:    code = SEL_0;
            2'd1:    code = SEL_1;
            2'd2:    code = SEL_2;
            2'd3:    code = SEL_3;
            default: code = SEL_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sel_arbiter4_if.sv
// Requester/consumer bundle of the select arbiter. The master side is the
// arbiter (producer of Sel/OutData/Ack); the slave side is its environment.
interface sel_arbiter4_if #(
    parameter int WIDTH = 32
) ();

    logic [3:0]       Req;
    logic [WIDTH-1:0] ReqData0;
    logic [WIDTH-1:0] ReqData1;
    logic [WIDTH-1:0] ReqData2;
    logic [WIDTH-1:0] ReqData3;
    logic [3:0]       Ack;
    logic [3:0]       Sel;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] OutData;

    modport master (
        input  Req,
        input  ReqData0,
        input  ReqData1,
        input  ReqData2,
        input  ReqData3,
        input  OutReady,
        output Ack,
        output Sel,
        output OutValid,
        output OutData
    );

    modport slave (
        output Req,
        output ReqData0,
        output ReqData1,
        output ReqData2,
        output ReqData3,
        output OutReady,
        input  Ack,
        input  Sel,
        input  OutValid,
        input  OutData
    );

endinterface

// File: rtl/sel_arbiter4_chk.sv
// Property checker for the select arbiter outputs: select/valid coherence,
// one-hot encodings, single-cycle Ack and transfer hold under backpressure.
module sel_arbiter4_chk #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       i_sel,
    input  logic [3:0]       i_ack,
    input  logic             i_out_valid,
    input  logic             i_out_ready,
    input  logic [WIDTH-1:0] i_out_data
);

    a_sel_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(i_sel))
        else $error("Sel is not zero or one-hot");

    a_sel_iff_valid: assert property (@(posedge clk) disable iff (rst)
        ((i_sel != 4'b0000) == i_out_valid))
        else $error("Sel nonzero does not track OutValid");

    a_ack_not_valid: assert property (@(posedge clk) disable iff (rst)
        !((|i_ack) && i_out_valid))
        else $error("Ack asserted together with OutValid");

    a_ack_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(i_ack))
        else $error("Ack is not at most one-hot");

    a_ack_single: assert property (@(posedge clk) disable iff (rst)
        (|i_ack) |=> (i_ack == 4'b0000))
        else $error("Ack lasted more than one cycle");

    // Without acceptance the granted transfer must not move.
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (i_out_valid && !i_out_ready) |=>
            (i_out_valid && $stable(i_sel) && $stable(i_out_data)))
        else $error("Transfer changed while waiting for OutReady");

endmodule

// File: rtl/sel_arbiter4_rr_pick4.sv
// Combinational round-robin picker: first set request bit scanning from the
// pointer upwards, wrapping 3 -> 0.
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [1:0] o_winner,
    output logic       o_valid
);

    logic [3:0] w_rot;
    logic [1:0] w_off;

    // Rotate requests so bit 0 is the requester the pointer names.
    always_comb begin
        w_rot = 4'b0000;
        case (i_ptr)
            2'd0:    w_rot = i_req;
            2'd1:    w_rot = {i_req[0],   i_req[3:1]};
            2'd2:    w_rot = {i_req[1:0], i_req[3:2]};
            2'd3:    w_rot = {i_req[2:0], i_req[3]};
            default: w_rot = i_req;
        endcase
    end

    // Fixed-priority search on the rotated vector gives the offset from the pointer.
    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign o_winner = i_ptr + w_off;
    assign o_valid  = |i_req;

endmodule

// File: rtl/sel_arbiter4.sv
// Round-robin arbiter producing the one-hot select for the write-back muxes.
// Grants one requester, holds its word until accepted, then acks it.
module sel_arbiter4
    import sel_arbiter4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    sel_arbiter4_if.master  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       r_winner;
    logic [1:0]       w_winner_nxt;
    logic [3:0]       r_sel;
    logic [3:0]       w_sel_nxt;
    logic [3:0]       r_ack;
    logic [3:0]       w_ack_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_out_data_nxt;

    logic [1:0]       w_pick_idx;
    logic             w_pick_valid;
    logic [WIDTH-1:0] w_pick_data;
    logic             w_handshake;

    rr_pick4 u_pick (
        .i_req    (bus.Req),
        .i_ptr    (r_ptr),
        .o_winner (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    assign w_handshake = r_out_valid & bus.OutReady;

    // Word of the requester the picker selected.
    always_comb begin
        w_pick_data = {WIDTH{1'b0}};
        case (w_pick_idx)
            2'd0:    w_pick_data = bus.ReqData0;
            2'd1:    w_pick_data = bus.ReqData1;
            2'd2:    w_pick_data = bus.ReqData2;
            2'd3:    w_pick_data = bus.ReqData3;
            default: w_pick_data = {WIDTH{1'b0}};
        endcase
    end

    // Next-state and next-output logic; Ack defaults low so it lasts one cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_winner_nxt    = r_winner;
        w_sel_nxt       = r_sel;
        w_ack_nxt       = SEL_NONE;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_winner_nxt    = w_pick_idx;
                    w_sel_nxt       = onehot4(w_pick_idx);
                    w_out_data_nxt  = w_pick_data;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_GRANT;
                end else begin
                    w_sel_nxt       = SEL_NONE;
                    w_out_data_nxt  = {WIDTH{1'b0}};
                    w_out_valid_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                // Requests are ignored here; the latched transfer is held as-is.
                if (w_handshake) begin
                    w_sel_nxt       = SEL_NONE;
                    w_out_data_nxt  = {WIDTH{1'b0}};
                    w_out_valid_nxt = 1'b0;
                    w_ack_nxt       = onehot4(r_winner);
                    w_ptr_nxt       = r_winner + 2'd1;
                    w_state_nxt     = ST_ACK;
                end else begin
                    w_state_nxt     = ST_GRANT;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_sel_nxt       = SEL_NONE;
                w_out_data_nxt  = {WIDTH{1'b0}};
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending transfer without an Ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_winner    <= 2'd0;
            r_sel       <= SEL_NONE;
            r_ack       <= SEL_NONE;
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_winner    <= w_winner_nxt;
            r_sel       <= w_sel_nxt;
            r_ack       <= w_ack_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    assign bus.Sel      = r_sel;
    assign bus.Ack      = r_ack;
    assign bus.OutValid = r_out_valid;
    assign bus.OutData  = r_out_data;

endmodule

// File: tb/tb_sel_arbiter4.sv
// Scoreboard bench for sel_arbiter4: expected grants are queued as requests
// are raised and compared when OutValid rises, held, and acknowledged.
module tb_sel_arbiter4;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [3:0]       sel;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sel_arbiter4_if #(.WIDTH(WIDTH)) bus ();

    sel_arbiter4 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sel_arbiter4_chk #(.WIDTH(WIDTH)) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_sel       (bus.Sel),
        .i_ack       (bus.Ack),
        .i_out_valid (bus.OutValid),
        .i_out_ready (bus.OutReady),
        .i_out_data  (bus.OutData)
    );

    exp_t       exp_q[$];
    exp_t       cur_exp;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         grants = 0;
    int         acks = 0;
    int         last_grant = -1;
    bit         check_period = 1'b0;
    bit         auto_reraise = 1'b0;
    logic       prev_valid = 1'b0;
    logic [3:0] drop_pend = 4'b0000;
    logic [3:0] raise_pend = 4'b0000;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] sel, input logic [WIDTH-1:0] data);
        exp_t e;
        e.sel  = sel;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // One clock: requester behaviour, then scoreboard monitoring of the outputs.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (drop_pend[i]) begin
                bus.Req[i]    = 1'b0;
                drop_pend[i]  = 1'b0;
                raise_pend[i] = auto_reraise;
            end else if (raise_pend[i]) begin
                bus.Req[i]    = 1'b1;
                raise_pend[i] = 1'b0;
            end
        end
        if (!rst) begin
            if (bus.OutValid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_grant", {60'd0, bus.Sel}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    cur_exp = e;
                    grants++;
                    chk_eq("grant_sel", {60'd0, bus.Sel}, {60'd0, e.sel});
                    chk_eq("grant_data", {32'd0, bus.OutData}, {32'd0, e.data});
                    if (check_period && last_grant >= 0)
                        chk_eq("grant_period", 64'(cyc - last_grant), 64'd3);
                    last_grant = cyc;
                end
            end else if (bus.OutValid) begin
                chk_eq("hold_sel", {60'd0, bus.Sel}, {60'd0, cur_exp.sel});
                chk_eq("hold_data", {32'd0, bus.OutData}, {32'd0, cur_exp.data});
            end else if (prev_valid) begin
                acks++;
                chk_eq("ack", {60'd0, bus.Ack}, {60'd0, cur_exp.sel});
                chk_eq("ack_sel_clear", {60'd0, bus.Sel}, 64'd0);
                drop_pend = drop_pend | bus.Ack;
            end else begin
                chk_eq("idle_no_ack", {60'd0, bus.Ack}, 64'd0);
            end
        end
        prev_valid = bus.OutValid;
    endtask

    task automatic run_until(input int target, input int budget);
        int k = 0;
        while (acks < target && k < budget) begin
            step();
            k++;
        end
        chk_eq("acks_within_budget", 64'(acks), 64'(target));
    endtask

    initial begin
        rst          = 1'b1;
        bus.Req      = 4'b0000;
        bus.ReqData0 = 32'h0000_0000;
        bus.ReqData1 = 32'h0000_0000;
        bus.ReqData2 = 32'h0000_0000;
        bus.ReqData3 = 32'h0000_0000;
        bus.OutReady = 1'b0;

        // Reset for two cycles, then five idle cycles.
        for (int i = 0; i < 2; i++) begin
            step();
            chk_eq("rst_sel", {60'd0, bus.Sel}, 64'd0);
            chk_eq("rst_valid", {63'd0, bus.OutValid}, 64'd0);
            chk_eq("rst_ack", {60'd0, bus.Ack}, 64'd0);
            chk_eq("rst_data", {32'd0, bus.OutData}, 64'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_eq("idle_sel", {60'd0, bus.Sel}, 64'd0);
            chk_eq("idle_valid", {63'd0, bus.OutValid}, 64'd0);
            chk_eq("idle_data", {32'd0, bus.OutData}, 64'd0);
        end

        // Rotation from Ptr=0 with all four requesting; three drain after re-raise stops.
        bus.ReqData0 = 32'h1000_0000;
        bus.ReqData1 = 32'h1111_1111;
        bus.ReqData2 = 32'h2222_2222;
        bus.ReqData3 = 32'h3333_3333;
        bus.OutReady = 1'b1;
        push_exp(4'b0001, 32'h1000_0000);
        push_exp(4'b0010, 32'h1111_1111);
        push_exp(4'b0100, 32'h2222_2222);
        push_exp(4'b1000, 32'h3333_3333);
        push_exp(4'b0001, 32'h1000_0000);
        push_exp(4'b0010, 32'h1111_1111);
        push_exp(4'b0100, 32'h2222_2222);
        check_period = 1'b1;
        auto_reraise = 1'b1;
        bus.Req      = 4'b1111;
        run_until(acks + 4, 40);
        auto_reraise = 1'b0;
        run_until(acks + 3, 40);
        check_period = 1'b0;
        step();
        step();

        // Single request; Ptr is now 3 after serving requester 2.
        bus.ReqData2 = 32'hDEAD_BEEF;
        push_exp(4'b0100, 32'hDEAD_BEEF);
        bus.Req = 4'b0100;
        step();
        chk_eq("single_latency", {63'd0, bus.OutValid}, 64'd1);
        step();
        chk_eq("single_ack", {60'd0, bus.Ack}, 64'h4);
        step();
        step();

        // Ptr=3: requester 0 beats requester 1 after wrapping.
        push_exp(4'b0001, 32'h1000_0000);
        push_exp(4'b0010, 32'h1111_1111);
        bus.Req = 4'b0011;
        run_until(acks + 2, 30);
        step();

        // Serve requester 3 (Ptr wraps to 0), then 1001 grants 0 before 3.
        push_exp(4'b1000, 32'h3333_3333);
        bus.Req = 4'b1000;
        run_until(acks + 1, 20);
        step();
        push_exp(4'b0001, 32'h1000_0000);
        push_exp(4'b1000, 32'h3333_3333);
        bus.Req = 4'b1001;
        run_until(acks + 2, 30);
        step();
        step();

        // Backpressure on requester 1 while its Req and data wander.
        bus.OutReady = 1'b0;
        bus.ReqData1 = 32'hCAFE_0001;
        push_exp(4'b0010, 32'hCAFE_0001);
        bus.Req = 4'b0010;
        step();
        for (int i = 0; i < 6; i++) begin
            bus.Req      = (i % 2 == 0) ? 4'b1101 : 4'b0000;
            bus.ReqData1 = 32'hBAD0_0000 + 32'(i);
            step();
            chk_eq("bp_no_ack", {60'd0, bus.Ack}, 64'd0);
        end
        bus.Req      = 4'b0010;
        bus.OutReady = 1'b1;
        step();
        chk_eq("bp_ack", {60'd0, bus.Ack}, 64'h2);
        step();
        step();

        // Reset while requester 3 is granted: no Ack, Ptr back to 0.
        bus.OutReady = 1'b0;
        push_exp(4'b1000, 32'h3333_3333);
        bus.Req = 4'b1000;
        step();
        step();
        rst = 1'b1;
        bus.Req = 4'b0000;
        step();
        chk_eq("mid_rst_sel", {60'd0, bus.Sel}, 64'd0);
        chk_eq("mid_rst_valid", {63'd0, bus.OutValid}, 64'd0);
        chk_eq("mid_rst_ack", {60'd0, bus.Ack}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq("post_rst_no_ack", {60'd0, bus.Ack}, 64'd0);
        end
        bus.OutReady = 1'b1;
        push_exp(4'b0001, 32'h1000_0000);
        push_exp(4'b1000, 32'h3333_3333);
        bus.Req = 4'b1001;
        run_until(acks + 2, 30);
        step();
        step();

        chk_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
